// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the F-stage fetch unit: reset constants and FSM state encoding.
// Port summary: none (package only).
// Imported by fetch_unit and fetch_unit_fd_reg.
package fetch_unit_pkg;

    localparam logic [31:0] PC_RESET_DEF  = 32'h0000_3000;  // text segment base
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic {
        F_FETCH = 1'b0,
        F_HOLD  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_fd_reg.sv
// F/D pipeline register: 64-bit {instr, pc}, loads on en, sync reset to {NOP, PC_RESET-4}.
// Ports: clk, reset (sync, high), en, instr_in/pc_in (next values), instr/pc (registered D-stage values).
// Latency: one cycle from en to output; holds value while en=0.
module fetch_unit_fd_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    logic [63:0] fd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fd_q <= {NOP_INSTR, PC_RESET - 32'd4};
        end else if (en) begin
            fd_q <= {instr_in, pc_in};
        end
    end

    assign instr = fd_q[63:32];
    assign pc    = fd_q[31:0];

endmodule

// File: rtl/fetch_unit.sv
// F-stage fetch unit: owns F_PC, a one-word hold buffer, the FETCH/HOLD FSM and the F/D register.
// Ports: clk/reset; D_stall and F_nextPC from hazard/NPC; F_imReq/F_imAddr/F_imValid/F_imRdata IM handshake;
// F_PC, F_busy, D_instr, D_PC outputs. Zero-wait IM gives 1 instr/cycle; stalled words park in hold_buf.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        D_stall,
    input  logic [31:0] F_nextPC,
    output logic        F_imReq,
    output logic [31:0] F_imAddr,
    input  logic        F_imValid,
    input  logic [31:0] F_imRdata,
    output logic [31:0] F_PC,
    output logic        F_busy,
    output logic [31:0] D_instr,
    output logic [31:0] D_PC
);

    fetch_state_t state, next_state;
    logic [31:0]  pc_q;
    logic [31:0]  hold_buf;
    logic         fd_load;   // F/D load event: also advances F_PC
    logic         buf_load;  // word arrived while D stalled

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= F_FETCH;
            pc_q     <= PC_RESET;
            hold_buf <= NOP_INSTR;
        end else begin
            state <= next_state;
            if (fd_load) begin
                pc_q <= F_nextPC;
            end
            if (buf_load) begin
                hold_buf <= F_imRdata;
            end
        end
    end

    always_comb begin
        next_state = state;
        fd_load    = 1'b0;
        buf_load   = 1'b0;
        F_imReq    = 1'b0;
        case (state)
            F_FETCH: begin
                F_imReq = 1'b1;
                if (F_imValid) begin
                    if (D_stall) begin
                        buf_load   = 1'b1;
                        next_state = F_HOLD;
                    end else begin
                        fd_load = 1'b1;
                    end
                end
            end
            F_HOLD: begin
                if (!D_stall) begin
                    fd_load    = 1'b1;
                    next_state = F_FETCH;
                end
            end
            default: begin
                next_state = F_FETCH;
            end
        endcase
    end

    // Depends only on state and F_imValid, so no combinational path from D_stall.
    assign F_busy   = (state == F_FETCH) && !F_imValid;
    assign F_imAddr = pc_q;
    assign F_PC     = pc_q;

    fetch_unit_fd_reg #(
        .PC_RESET  (PC_RESET),
        .NOP_INSTR (NOP_INSTR)
    ) u_fd_reg (
        .clk      (clk),
        .reset    (reset),
        .en       (fd_load),
        .instr_in ((state == F_HOLD) ? hold_buf : F_imRdata),
        .pc_in    (pc_q),
        .instr    (D_instr),
        .pc       (D_PC)
    );

endmodule
